// File: rtl/uart_rx_fsm_if.sv
// Signal bundle between the UART RX control FSM (slave side) and the
// serial line plus the bit-level checkers, sampler and deserializer (master side).
interface uart_rx_fsm_if #(
    parameter int PRESC_W = 6
);
    logic               RX_IN;
    logic [PRESC_W-1:0] PRESCALE;
    logic               PAR_EN;
    logic               sampled_bit;
    logic               strt_glitch;
    logic               par_err;
    logic               stp_err;

    logic               dat_samp_en;
    logic               strt_chk_en;
    logic               deser_en;
    logic               par_chk_en;
    logic               stp_chk_en;
    logic               data_valid;
    logic               parity_error;
    logic               framing_error;

    modport slave (
        input  RX_IN, PRESCALE, PAR_EN, sampled_bit, strt_glitch, par_err, stp_err,
        output dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en,
               data_valid, parity_error, framing_error
    );

    modport master (
        output RX_IN, PRESCALE, PAR_EN, sampled_bit, strt_glitch, par_err, stp_err,
        input  dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en,
               data_valid, parity_error, framing_error
    );
endinterface

// File: rtl/uart_rx_fsm.sv
// UART receive control FSM: tracks edges within each bit and bits within the frame,
// strobes the helper blocks at the check edge and reports one outcome pulse per frame.
module uart_rx_fsm #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic          CLK,
    input  logic          RST,
    uart_rx_fsm_if.slave  bus
);

    localparam int                 BIT_W    = $clog2(DATA_WIDTH) + 1;
    localparam logic [BIT_W-1:0]   BIT_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [PRESC_W-1:0] PRESC_RST = PRESC_W'(8);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t             state, state_nxt;
    logic [PRESC_W-1:0] edge_cnt, edge_nxt;
    logic [BIT_W-1:0]   bit_cnt, bit_nxt;
    logic [PRESC_W-1:0] presc, presc_nxt;
    logic               par_en, par_en_nxt;
    logic               frame_err, frame_err_nxt;
    logic               valid_q, valid_nxt;
    logic               perr_q, perr_nxt;
    logic               ferr_q, ferr_nxt;

    logic [PRESC_W-1:0] last_edge;
    logic [PRESC_W-1:0] chk_edge;
    logic               bit_end;
    logic               at_chk;

    // The sampled bit feeds the deserializer directly; the FSM only sequences it.
    logic unused_sampled_bit;
    assign unused_sampled_bit = bus.sampled_bit;

    assign last_edge = presc - PRESC_W'(1);
    assign chk_edge  = (presc >> 1) + PRESC_W'(2);
    assign bit_end   = (edge_cnt == last_edge);
    assign at_chk    = (edge_cnt == chk_edge);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            edge_cnt  <= '0;
            bit_cnt   <= '0;
            presc     <= PRESC_RST;
            par_en    <= 1'b0;
            frame_err <= 1'b0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            edge_cnt  <= edge_nxt;
            bit_cnt   <= bit_nxt;
            presc     <= presc_nxt;
            par_en    <= par_en_nxt;
            frame_err <= frame_err_nxt;
            valid_q   <= valid_nxt;
            perr_q    <= perr_nxt;
            ferr_q    <= ferr_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        edge_nxt      = bit_end ? '0 : edge_cnt + PRESC_W'(1);
        bit_nxt       = bit_cnt;
        presc_nxt     = presc;
        par_en_nxt    = par_en;
        frame_err_nxt = frame_err;
        valid_nxt     = 1'b0;
        perr_nxt      = 1'b0;
        ferr_nxt      = 1'b0;

        unique case (state)
            IDLE: begin
                edge_nxt = '0;
                // The detect cycle is edge 0 of the start bit, so counting resumes at 1.
                if (!bus.RX_IN) begin
                    state_nxt     = START;
                    edge_nxt      = PRESC_W'(1);
                    presc_nxt     = bus.PRESCALE;
                    par_en_nxt    = bus.PAR_EN;
                    frame_err_nxt = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    if (bus.strt_glitch) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = DATA;
                        bit_nxt   = '0;
                    end
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt == BIT_LAST) begin
                        state_nxt = par_en ? PARITY : STOP;
                    end else begin
                        bit_nxt = bit_cnt + BIT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_nxt     = STOP;
                    frame_err_nxt = bus.par_err;
                end
            end
            STOP: begin
                // A bad stop bit outranks a parity failure.
                if (bit_end) begin
                    state_nxt = IDLE;
                    ferr_nxt  = bus.stp_err;
                    perr_nxt  = !bus.stp_err && frame_err;
                    valid_nxt = !bus.stp_err && !frame_err;
                end
            end
            default: begin
                state_nxt = IDLE;
                edge_nxt  = '0;
            end
        endcase
    end

    assign bus.dat_samp_en   = (state != IDLE);
    assign bus.strt_chk_en   = (state == START)  && at_chk;
    assign bus.deser_en      = (state == DATA)   && at_chk;
    assign bus.par_chk_en    = (state == PARITY) && at_chk;
    assign bus.stp_chk_en    = (state == STOP)   && at_chk;
    assign bus.data_valid    = valid_q;
    assign bus.parity_error  = perr_q;
    assign bus.framing_error = ferr_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Randomized scoreboard bench for uart_rx_fsm: frames are described by bit period
// arithmetic, expected strobes/outcomes are queued and a negedge monitor matches them.
module tb_uart_rx_fsm;

    localparam int W       = 8;
    localparam int PRESC_W = 6;

    typedef struct {
        int cyc;
        int kind;
    } ev_t;

    logic CLK;
    logic RST;
    int   cyc;
    int   checks;
    int   errors;
    bit   mon_on;
    logic samp_prev;
    ev_t  exp_q[$];

    string kind_name [9] = '{"data_valid", "parity_error", "framing_error", "strt_chk_en",
                             "deser_en", "par_chk_en", "stp_chk_en", "samp_rise", "samp_fall"};

    uart_rx_fsm_if #(.PRESC_W(PRESC_W)) bus ();

    uart_rx_fsm #(
        .DATA_WIDTH (W),
        .PRESC_W    (PRESC_W)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic int pick_p();
        case ($urandom_range(0, 2))
            0:       return 8;
            1:       return 16;
            default: return 32;
        endcase
    endfunction

    function automatic logic [7:0] out_vec();
        return {bus.dat_samp_en, bus.strt_chk_en, bus.deser_en, bus.par_chk_en,
                bus.stp_chk_en, bus.data_valid, bus.parity_error, bus.framing_error};
    endfunction

    task automatic check_vec(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: outputs got %b required %b at cycle %0d", name, got, want, cyc);
        end
    endtask

    // Match one observed output event against the head of the expected queue.
    task automatic check_output(input int k);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_%s: got it at cycle %0d, required nothing", kind_name[k], cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc) begin
                errors++;
                $display("[TB] FAIL event_order: got %s at cycle %0d, required %s at cycle %0d",
                         kind_name[k], cyc, kind_name[e.kind], e.cyc);
            end
        end
    endtask

    always @(negedge CLK) begin
        logic [8:0] seen;
        if (mon_on) begin
            seen    = '0;
            seen[0] = bus.data_valid;
            seen[1] = bus.parity_error;
            seen[2] = bus.framing_error;
            seen[3] = bus.strt_chk_en;
            seen[4] = bus.deser_en;
            seen[5] = bus.par_chk_en;
            seen[6] = bus.stp_chk_en;
            seen[7] = bus.dat_samp_en & ~samp_prev;
            seen[8] = ~bus.dat_samp_en & samp_prev;
            samp_prev = bus.dat_samp_en;
            for (int k = 0; k < 9; k++) begin
                if (seen[k]) check_output(k);
            end
        end
    end

    task automatic idle_cycles(input int n);
        for (int g = 0; g < n; g++) begin
            bus.RX_IN       = 1'b1;
            bus.PRESCALE    = PRESC_W'(pick_p());
            bus.PAR_EN      = 1'($urandom_range(0, 1));
            bus.sampled_bit = 1'($urandom_range(0, 1));
            bus.strt_glitch = 1'($urandom_range(0, 1));
            bus.par_err     = 1'($urandom_range(0, 1));
            bus.stp_err     = 1'($urandom_range(0, 1));
            step();
        end
    endtask

    // One frame starting with the line falling now. Bit b of the frame spans
    // cycles [b*p, (b+1)*p) relative to the detect cycle; outcome lands at n*p.
    task automatic apply_stimulus(input int p, input bit pe, input logic [W-1:0] data,
                                  input bit glitch, input bit perr, input bit serr,
                                  input bit brk, input int rst_bit, input int gap);
        int   n, chk, total, s, r_cyc, outcome;
        bit   aborted;
        logic par_bit;
        ev_t  evs[$];

        chk     = p / 2 + 2;
        n       = W + 2 + (pe ? 1 : 0);
        total   = glitch ? p : n * p;
        s       = cyc;
        r_cyc   = (rst_bit >= 0) ? s + rst_bit * p + 3 : -1;
        par_bit = ^data;
        aborted = 1'b0;

        evs.push_back('{s + 1, 7});
        evs.push_back('{s + chk, 3});
        if (glitch) begin
            evs.push_back('{s + p, 8});
        end else begin
            for (int i = 0; i < W; i++) evs.push_back('{s + (1 + i) * p + chk, 4});
            if (pe) evs.push_back('{s + (1 + W) * p + chk, 5});
            evs.push_back('{s + (n - 1) * p + chk, 6});
            if (serr)             outcome = 2;
            else if (pe && perr)  outcome = 1;
            else                  outcome = 0;
            evs.push_back('{s + n * p, outcome});
            evs.push_back('{s + n * p, 8});
        end
        foreach (evs[i]) begin
            if (r_cyc < 0 || evs[i].cyc <= r_cyc) exp_q.push_back(evs[i]);
        end
        if (r_cyc >= 0) exp_q.push_back('{r_cyc + 1, 8});

        for (int c = 0; c < total && !aborted; c++) begin
            int b, e;
            b = c / p;
            e = c % p;
            if (c == 0) begin
                bus.PRESCALE = PRESC_W'(p);
                bus.PAR_EN   = pe;
            end else begin
                bus.PRESCALE = PRESC_W'(pick_p());
                bus.PAR_EN   = 1'($urandom_range(0, 1));
            end
            if (glitch)              bus.RX_IN = (c < 2) ? 1'b0 : 1'b1;
            else if (brk)            bus.RX_IN = 1'b0;
            else if (b == 0)         bus.RX_IN = 1'b0;
            else if (b <= W)         bus.RX_IN = data[b-1];
            else if (pe && b == W+1) bus.RX_IN = par_bit;
            else                     bus.RX_IN = 1'b1;
            bus.sampled_bit = bus.RX_IN;
            bus.strt_glitch = (b == 0 && e > chk) ? glitch : 1'($urandom_range(0, 1));
            bus.par_err     = (!glitch && pe && b == W + 1 && e > chk) ? perr : 1'($urandom_range(0, 1));
            bus.stp_err     = (!glitch && b == n - 1 && e > chk) ? serr : 1'($urandom_range(0, 1));
            RST             = (s + c == r_cyc);
            step();
            if (RST) begin
                RST        = 1'b0;
                bus.RX_IN  = 1'b1;
                check_vec("reset_mid_frame", out_vec(), 8'h00);
                aborted    = 1'b1;
            end
        end
        idle_cycles(gap);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        mon_on    = 1'b0;
        samp_prev = 1'b0;
        RST       = 1'b1;
        bus.RX_IN       = 1'b1;
        bus.PRESCALE    = PRESC_W'(16);
        bus.PAR_EN      = 1'b0;
        bus.sampled_bit = 1'b1;
        bus.strt_glitch = 1'b0;
        bus.par_err     = 1'b0;
        bus.stp_err     = 1'b0;
        step();
        step();
        RST = 1'b0;
        check_vec("reset_state", out_vec(), 8'h00);
        mon_on = 1'b1;
        idle_cycles(3);

        $display("[TB] directed frames");
        apply_stimulus(8,  1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, -1, 2);
        apply_stimulus(16, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, -1, 2);
        apply_stimulus(8,  1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, -1, 2);
        apply_stimulus(8,  1'b1, 8'h0F, 1'b0, 1'b1, 1'b1, 1'b0, -1, 2);
        apply_stimulus(8,  1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, -1, 2);
        apply_stimulus(8,  1'b0, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0,  4, 2);
        apply_stimulus(8,  1'b0, 8'h42, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0);
        apply_stimulus(8,  1'b0, 8'h24, 1'b0, 1'b0, 1'b0, 1'b0, -1, 2);
        apply_stimulus(8,  1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, -1, 0);
        apply_stimulus(8,  1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, -1, 3);
        apply_stimulus(32, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1);

        $display("[TB] random frames");
        for (int f = 0; f < 25; f++) begin
            int  p;
            bit  pe, gl, pr, sr;
            p  = pick_p();
            pe = 1'($urandom_range(0, 1));
            gl = ($urandom_range(0, 7) == 0);
            pr = ($urandom_range(0, 3) == 0);
            sr = ($urandom_range(0, 5) == 0);
            apply_stimulus(p, pe, W'($urandom), gl, pr, sr, 1'b0,
                           ($urandom_range(0, 9) == 0) ? 2 : -1, $urandom_range(0, 3));
        end

        idle_cycles(4);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL leftover_events: got %0d still pending, required 0 (next %s at cycle %0d)",
                     exp_q.size(), kind_name[exp_q[0].kind], exp_q[0].cyc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
